// File: rtl/alu_control_seq_pkg.sv
// Shared definitions for the ALU control sequencer and its decoder.
// Holds ALUOp class constants, R-type function codes, ALUOperation codes,
// FSM state encoding and the decoder result payload.
package alu_control_seq_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 8;

  // ALUOp classes from the main control unit
  localparam logic [2:0] AOP_R_TYPE = 3'b111;
  localparam logic [2:0] AOP_ADDI   = 3'b100;
  localparam logic [2:0] AOP_ORI    = 3'b101;
  localparam logic [2:0] AOP_BRANCH = 3'b001;

  // R-type function field values
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_INC  = 6'b001001;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  // ALUOperation codes
  localparam logic [CODE_W-1:0] OP_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] OP_OR   = 4'b0001;
  localparam logic [CODE_W-1:0] OP_NOR  = 4'b0010;
  localparam logic [CODE_W-1:0] OP_ADD  = 4'b0011;
  localparam logic [CODE_W-1:0] OP_SUB  = 4'b0100;
  localparam logic [CODE_W-1:0] OP_INC  = 4'b1001;
  localparam logic [CODE_W-1:0] OP_MULT = 4'b1010;
  localparam logic [CODE_W-1:0] OP_DIV  = 4'b1011;
  localparam logic [CODE_W-1:0] OP_MFHI = 4'b1100;
  localparam logic [CODE_W-1:0] OP_MFLO = 4'b1101;
  localparam logic [CODE_W-1:0] OP_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MD_BUSY = 2'b01,
    ST_MD_DONE = 2'b10
  } state_e;

  // Decoder result
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              is_md;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decoder, shared with the single-cycle core.
// Ports: alu_op/funct selector in; dec_c = {code, is_md, illegal} out.
// Unrecognised selectors give code 1001 with illegal set.
module alu_op_decode
  import alu_control_seq_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec_c
);

  // Selector -> operation code lookup
  always_comb begin
    dec_c.code    = OP_INC;
    dec_c.is_md   = 1'b0;
    dec_c.illegal = 1'b0;
    case (alu_op)
      ALUOP_W'(AOP_ADDI):   dec_c.code = OP_ADD;
      ALUOP_W'(AOP_ORI):    dec_c.code = OP_OR;
      ALUOP_W'(AOP_BRANCH): dec_c.code = OP_SUB;
      ALUOP_W'(AOP_R_TYPE): begin
        case (funct)
          FUNCT_W'(FN_AND):  dec_c.code = OP_AND;
          FUNCT_W'(FN_OR):   dec_c.code = OP_OR;
          FUNCT_W'(FN_NOR):  dec_c.code = OP_NOR;
          FUNCT_W'(FN_ADD):  dec_c.code = OP_ADD;
          FUNCT_W'(FN_INC):  dec_c.code = OP_INC;
          FUNCT_W'(FN_MFHI): dec_c.code = OP_MFHI;
          FUNCT_W'(FN_MFLO): dec_c.code = OP_MFLO;
          FUNCT_W'(FN_MULT): begin
            dec_c.code  = OP_MULT;
            dec_c.is_md = 1'b1;
          end
          FUNCT_W'(FN_DIV): begin
            dec_c.code  = OP_DIV;
            dec_c.is_md = 1'b1;
          end
          default: dec_c.illegal = 1'b1;
        endcase
      end
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control unit with valid/ready intake and MULT/DIV sequencing.
// Ports: clk, reset (async active-low), flush_i, valid_i/ready_o handshake,
//   ALUOp/ALUFunction in, ALUOperation + op_valid_o out, busy_o, md_start_o,
//   hilo_we_o, illegal_o.
// Optional: define ALU_CONTROL_ILLEGAL_TRAP_EN to map unrecognised selectors
//   to the ALU NOP code (1111) and pulse illegal_o; otherwise they give 1001
//   and illegal_o stays 0.
module alu_control_seq
  import alu_control_seq_pkg::*;
#(
  parameter int unsigned ALUOP_W   = 3,
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned OPER_W    = 4,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNCT_W-1:0] ALUFunction,
  output logic [OPER_W-1:0]  ALUOperation,
  output logic               op_valid_o,
  output logic               busy_o,
  output logic               md_start_o,
  output logic               hilo_we_o,
  output logic               illegal_o
);

`ifdef ALU_CONTROL_ILLEGAL_TRAP_EN
  localparam logic [CODE_W-1:0] ILLEGAL_CODE = OP_NOP;
  localparam logic              TRAP_EN      = 1'b1;
`else
  localparam logic [CODE_W-1:0] ILLEGAL_CODE = OP_INC;
  localparam logic              TRAP_EN      = 1'b0;
`endif

  // MD_BUSY lasts MD_CYCLES-1 cycles (count down to 0), MD_DONE one more
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 2);

  dec_t dec_c;

  alu_op_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .alu_op (ALUOp),
    .funct  (ALUFunction),
    .dec_c  (dec_c)
  );

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [OPER_W-1:0]   oper_q,     oper_d;
  logic                op_valid_q, op_valid_d;
  logic                md_start_q, md_start_d;
  logic                hilo_we_q,  hilo_we_d;
  logic                illegal_q,  illegal_d;
  logic                ready_q,    ready_d;
  logic                busy_q,     busy_d;
  logic                accept_c;

  // ready_q is high exactly in IDLE, so it gates acceptance directly
  assign accept_c = valid_i & ready_q & ~flush_i;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oper_d     = oper_q;
    op_valid_d = 1'b0;
    md_start_d = 1'b0;
    hilo_we_d  = 1'b0;
    illegal_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          oper_d     = OPER_W'(dec_c.illegal ? ILLEGAL_CODE : dec_c.code);
          op_valid_d = 1'b1;
          illegal_d  = dec_c.illegal & TRAP_EN;
          if (dec_c.is_md) begin
            state_d    = ST_MD_BUSY;
            cnt_d      = CNT_LOAD;
            md_start_d = 1'b1;
          end
        end
      end
      ST_MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = ST_MD_DONE;
          hilo_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Abort wins; a commit already on hilo_we_o this cycle is unaffected
    if (flush_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      hilo_we_d = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      oper_q     <= OPER_W'(OP_INC);
      op_valid_q <= 1'b0;
      md_start_q <= 1'b0;
      hilo_we_q  <= 1'b0;
      illegal_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oper_q     <= oper_d;
      op_valid_q <= op_valid_d;
      md_start_q <= md_start_d;
      hilo_we_q  <= hilo_we_d;
      illegal_q  <= illegal_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign ALUOperation = oper_q;
  assign op_valid_o   = op_valid_q;
  assign md_start_o   = md_start_q;
  assign hilo_we_o    = hilo_we_q;
  assign illegal_o    = illegal_q;

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, parametrised ALU control unit with a valid/ready handshake toward the decode stage.
- Decodes {ALUOp, ALUFunction} into an ALU operation code, as the single-cycle control does.
- Also sequences iterative MULT/DIV operations. It holds a busy/stall window of MD_CYCLES and pulses a HI/LO write-enable on completion.
- Sits between the main control unit / instruction register and the ALU plus multiply-divide datapath.

Parameters:
- ALUOP_W, 3: width of ALUOp.
- FUNCT_W, 6: width of the R-type function field.
- OPER_W, 4: width of ALUOperation. Must be ≥ 4.
- MD_CYCLES, 32: cycles a MULT/DIV occupies the multiply-divide unit. Legal range 2..255.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- flush_i, input, 1: synchronous abort of any accepted or in-flight operation.
- valid_i, input, 1: ALUOp/ALUFunction are valid this cycle.
- ready_o, output, 1: block can accept. Equals 1 exactly when state = IDLE.
- ALUOp, input, ALUOP_W: operation class from the main control unit.
- ALUFunction, input, FUNCT_W: instruction function field.
- ALUOperation, output, OPER_W: registered ALU operation code.
- op_valid_o, output, 1: one-cycle pulse; ALUOperation was updated by an accepted instruction.
- busy_o, output, 1: high while a MULT/DIV is in progress (state MD_BUSY or MD_DONE).
- md_start_o, output, 1: one-cycle pulse that starts the multiply-divide unit.
- hilo_we_o, output, 1: one-cycle pulse that commits the HI/LO result.
- illegal_o, output, 1: unrecognised selector flag. See Optional Feature.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, counter = 0.
  - ALUOperation = 4'b1001.
  - op_valid_o, md_start_o, hilo_we_o, illegal_o = 0.
  - Reset mid-MULT/DIV aborts it silently; no hilo_we_o is issued.
- Accept: a transfer occurs when valid_i & ready_o & !flush_i. Latency is 1 cycle: ALUOperation and op_valid_o are registered on the accepting edge.
- Decode table (selector = {ALUOp, ALUFunction}; "x" = don't care):
  - 111_100100 AND → 0000.
  - 111_100101 OR → 0001.
  - 111_100111 NOR → 0010.
  - 111_100000 ADD → 0011.
  - 100_x ADDI → 0011.
  - 101_x ORI → 0001.
  - 001_x BEQ/BNE → 0100.
  - 111_001001 INC → 1001.
  - 111_011000 MULT → 1010.
  - 111_011010 DIV → 1011.
  - 111_010000 MFHI → 1100.
  - 111_010010 MFLO → 1101.
  - Any other selector → 1001 (illegal).
- Upper ALUOperation bits above 4 are zero when OPER_W > 4.
- FSM states: IDLE, MD_BUSY, MD_DONE.
  - IDLE → MD_BUSY: on accepting MULT or DIV. md_start_o = 1 in the following cycle; counter loads MD_CYCLES-2.
  - MD_BUSY: counter decrements each cycle. At counter = 0 → MD_DONE. ALUOperation holds the MULT/DIV code.
  - MD_DONE: hilo_we_o = 1 for this cycle only, then → IDLE.
  - Result: MULT/DIV accepted at edge N; hilo_we_o high during cycle N+MD_CYCLES; ready_o high again at N+MD_CYCLES+1.
  - All other ops: stay in IDLE. Back-to-back accepts every cycle.
- valid_i while ready_o = 0: ignored. Upstream holds the instruction.
- flush_i:
  - In any state, next state = IDLE and counter cleared.
  - hilo_we_o and op_valid_o are suppressed that cycle.
  - ALUOperation keeps its last value.
  - flush_i with valid_i in the same cycle: flush wins, nothing is accepted.
  - flush_i during MD_DONE: the hilo_we_o pulse of that cycle is still allowed. It is registered, so the commit was already decided.
- MFHI/MFLO are single-cycle. They are legal only when busy_o = 0, which the handshake guarantees.

Optional Feature:
- Macro: ALU_CONTROL_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised selector drives ALUOperation = 4'b1111 (ALU NOP code).
  - illegal_o pulses with op_valid_o.
- Undefined:
  - An unrecognised selector yields 4'b1001.
  - illegal_o is tied 0.

Decomposition:
- Shared package / header holds:
  - ALUOp class constants: R_TYPE=111, ADDI=100, ORI=101, BRANCH=001.
  - Function-code constants.
  - ALUOperation codes (0000..1101, 1111).
  - FSM state encodings.
- One natural sub-module: alu_op_decode. It is purely combinational, maps selector → {code, is_md, illegal}, and is reusable by the single-cycle core.
- The top level holds the handshake, FSM and counter.

Test Plan:
- Reset asserted mid-stream → ALUOperation = 1001, ready_o = 1, all pulses 0, asynchronously without a clock edge.
- Back-to-back accepts of AND, NOR, ADDI (100_010101), BEQ (001_000000) → ALUOperation 0000, 0010, 0011, 0100 on consecutive cycles, op_valid_o = 1 each cycle.
- MULT (111_011000) with MD_CYCLES = 4 → md_start_o at N+1, busy_o N+1..N+4, hilo_we_o at N+4 only, ready_o returns at N+5, concurrent valid_i ignored.
- DIV accepted, flush_i at N+2 → no hilo_we_o, ready_o = 1 at N+3, next ADD accepted normally.
- Selector 111_111111 → 1001 and illegal_o = 0 without the macro; 1111 and illegal_o pulse with ALU_CONTROL_ILLEGAL_TRAP_EN.
- valid_i and flush_i high together in IDLE with MULT → no accept, op_valid_o = 0, state remains IDLE.
